// File: rtl/pipelined_multiplier_pkg.sv
// Shared defaults and elaboration helpers for the pipelined shift-and-add multiplier.
package pipelined_multiplier_pkg;

  localparam int DefaultWidth        = 8;
  localparam int DefaultBitsPerStage = 1;

  // Number of accumulate stages; guarded so an illegal zero step still elaborates far
  // enough to report the parameter error instead of dividing by zero.
  function automatic int num_stages(int w, int bps);
    if (bps <= 0) begin
      return 1;
    end
    return w / bps;
  endfunction

  // True when the width / step combination describes a buildable pipeline.
  function automatic bit params_legal(int w, int bps);
    return (w >= 2) && (bps >= 1) && (bps <= w) && ((w % bps) == 0);
  endfunction

endpackage

// File: rtl/pipelined_multiplier_stage.sv
// One accumulate stage: adds the partial product for its slice of |b| and forwards the
// operand magnitudes, sign flag and valid bit. The last stage applies the sign.
module pipelined_multiplier_stage
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH          = DefaultWidth,
  parameter int BITS_PER_STAGE = DefaultBitsPerStage,
  parameter int INDEX          = 1,
  parameter bit LAST           = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 neg_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 neg_o,
  output logic [2*WIDTH-1:0]   acc_o
);

  localparam int AccW = 2 * WIDTH;
  localparam int Lsb  = (INDEX - 1) * BITS_PER_STAGE;

  logic [BITS_PER_STAGE-1:0] digit;
  logic [AccW-1:0]           pp;
  logic [AccW-1:0]           sum;
  logic [AccW-1:0]           acc_d;

  logic                      valid_q;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic                      neg_q;
  logic [AccW-1:0]           acc_q;

  // Partial product for this stage's multiplier digit, then optional final negation.
  always_comb begin
    digit = b_i[Lsb +: BITS_PER_STAGE];
    pp    = AccW'(a_i) * AccW'(digit);
    pp    = pp << Lsb;
    sum   = acc_i + pp;
    acc_d = (LAST && neg_i) ? -sum : sum;
  end

  // Stage register; every field, including bubbles, moves only when the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
    end else if (adv) begin
      valid_q <= valid_i;
      a_q     <= a_i;
      b_q     <= b_i;
      neg_q   <= neg_i;
      acc_q   <= acc_d;
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign neg_o   = neg_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined shift-and-add multiplier with valid/ready handshake and per-operation
// signed/unsigned mode. Capture stage converts operands to magnitudes; the stage chain
// accumulates BITS_PER_STAGE multiplier bits per cycle.
module pipelined_multiplier
  import pipelined_multiplier_pkg::*;
#(
  parameter int WIDTH          = DefaultWidth,
  parameter int BITS_PER_STAGE = DefaultBitsPerStage
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int STAGES = num_stages(WIDTH, BITS_PER_STAGE);
  localparam int AccW   = 2 * WIDTH;

  if (!params_legal(WIDTH, BITS_PER_STAGE)) begin : g_bad_params
    $error("pipelined_multiplier: WIDTH=%0d BITS_PER_STAGE=%0d is not a legal combination",
           WIDTH, BITS_PER_STAGE);
  end

  logic             adv;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             neg_d;

  logic             cap_valid_q;
  logic [WIDTH-1:0] cap_a_q;
  logic [WIDTH-1:0] cap_b_q;
  logic             cap_neg_q;

  logic             valid_s [1:STAGES];
  logic [WIDTH-1:0] a_s     [1:STAGES];
  logic [WIDTH-1:0] b_s     [1:STAGES];
  logic             neg_s   [1:STAGES];
  logic [AccW-1:0]  acc_s   [1:STAGES];

  // Whole pipe moves in lockstep whenever the output slot is empty or being drained.
  assign adv         = !out_valid | out_ready;
  assign in_ready    = adv & rst_n;
  assign out_valid   = valid_s[STAGES];
  assign out_product = out_valid ? acc_s[STAGES] : '0;

  // Operand magnitudes and result sign; -(2^(W-1)) still fits as an unsigned magnitude.
  always_comb begin
    abs_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    abs_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    neg_d = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  end

  // Capture stage register; in_ready is 1 whenever adv is 1 outside reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_neg_q   <= 1'b0;
    end else if (adv) begin
      cap_valid_q <= in_valid;
      cap_a_q     <= abs_a;
      cap_b_q     <= abs_b;
      cap_neg_q   <= neg_d;
    end
  end

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    logic             valid_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             neg_in;
    logic [AccW-1:0]  acc_in;

    if (g == 1) begin : g_first
      assign valid_in = cap_valid_q;
      assign a_in     = cap_a_q;
      assign b_in     = cap_b_q;
      assign neg_in   = cap_neg_q;
      assign acc_in   = '0;
    end else begin : g_rest
      assign valid_in = valid_s[g-1];
      assign a_in     = a_s[g-1];
      assign b_in     = b_s[g-1];
      assign neg_in   = neg_s[g-1];
      assign acc_in   = acc_s[g-1];
    end

    pipelined_multiplier_stage #(
      .WIDTH          (WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE),
      .INDEX          (g),
      .LAST           (g == STAGES)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .valid_i (valid_in),
      .a_i     (a_in),
      .b_i     (b_in),
      .neg_i   (neg_in),
      .acc_i   (acc_in),
      .valid_o (valid_s[g]),
      .a_o     (a_s[g]),
      .b_o     (b_s[g]),
      .neg_o   (neg_s[g]),
      .acc_o   (acc_s[g])
    );
  end

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, fully pipelined shift-and-add multiplier with a valid/ready stream interface and per-operation signed/unsigned mode. It accepts one operand pair per cycle, retires `BITS_PER_STAGE` multiplier bits per stage, and applies backpressure from the consumer to the producer. It sits between an operand producer and a result consumer, both streaming, anywhere the design needs multiply throughput without a DSP primitive.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be at least 2.
- `BITS_PER_STAGE`, default 1: multiplier bits consumed per accumulate stage. Must be in 1..`WIDTH` and must divide `WIDTH`. Any violation is an elaboration-time `$error`.
- Derived: `STAGES = WIDTH / BITS_PER_STAGE`.
- `clk` input 1: single clock. All logic is on the posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept this cycle.
- `in_a` input `WIDTH`: multiplicand.
- `in_b` input `WIDTH`: multiplier.
- `in_signed` input 1: 1 = two's-complement operands, 0 = unsigned. Sampled with the operands.
- `out_valid` output 1: product present.
- `out_ready` input 1: consumer accepts the product.
- `out_product` output `2*WIDTH`: product. Two's complement when the operation was signed.

## Operation
- Accept: a transfer happens at a posedge where `in_valid & in_ready`.
- Advance: `adv = !out_valid | out_ready`.
  - `in_ready = adv & rst_n`.
  - All stages shift together when `adv=1` and hold when `adv=0`.
  - Bubbles shift like data; they are not collapsed.
- Stage 0 (capture) registers:
  - `|a|` and `|b|` as `WIDTH`-bit unsigned magnitudes. In signed mode a negative operand is negated. |−2^(W−1)| = 2^(W−1) fits in `WIDTH` bits.
  - `neg = in_signed & (a[W-1] ^ b[W-1])`.
  - A valid bit.
- Stage i (1..`STAGES`) adds to the accumulator:
  - Bits `[i*BPS-1 : (i-1)*BPS]` of `|b|` times `|a|`, shifted left by `(i-1)*BPS`.
  - Accumulator is `2*WIDTH` bits wide. It cannot overflow, because the largest product magnitude is (2^W−1)^2.
  - `|a|`, `|b|`, `neg` and valid travel alongside the accumulator.
- Final stage (`STAGES`): registers `neg ? -(acc + pp) : (acc + pp)` truncated to `2*WIDTH` bits. Its valid bit is `out_valid`.
- `out_product` reads 0 whenever `out_valid=0`. While `out_valid & !out_ready`, it is held stable.
- Results leave in acceptance order. Exactly one result is produced per accepted pair: no loss, no duplication.

## Timing
- Latency: a pair accepted at edge E gives `out_valid=1` from edge E+`STAGES`, provided `adv=1` throughout. Each `adv=0` cycle adds one cycle.
  - `WIDTH=8`, `BPS=1`: 8 cycles.
- Throughput: one result per cycle while `out_ready=1`.
- Simultaneous events: in the same cycle, the output may be consumed and a new input accepted. `in_ready` depends combinationally on `out_ready`; there is no combinational path from `in_valid` to any output.
- Reset: at any posedge with `rst_n=0`:
  - All valid bits clear.
  - All data registers become 0.
  - `in_ready` is 0 while `rst_n` is low.
  - After the reset edge, `out_valid=0` and `out_product=0`.
  - Operations in flight at reset are discarded and never appear.
- `in_ready` is 1 on the first cycle after `rst_n` rises, because `out_valid=0`.

## Structure
- Package `pipelined_multiplier_pkg`:
  - `function automatic int num_stages(int w, int bps)`.
  - Parameter-legality check helper.
  - `localparam` default values.
- Sub-module `pipelined_multiplier_stage`:
  - Parameters `WIDTH`, `BITS_PER_STAGE`, `INDEX`, `LAST`.
  - One accumulate stage plus its valid/`neg`/operand registers, with an `adv` enable.
  - `LAST=1` adds the conditional negation.
  - Instantiated `STAGES` times via generate.
- Top level holds: capture stage, `adv`/`in_ready` logic, output gating.

## Test plan
- `WIDTH=8`, `BPS=1`, unsigned: 255×255 accepted at edge E → `out_product=0xFE01` with `out_valid` at E+8. Also 0×200 → `0x0000`.
- Signed mode, 8-bit:
  - 0x80×0x80 → `0x4000`.
  - 0x80×0x7F → `0xC080`.
  - 0xFF×0x02 → `0xFFFE`.
  - Same 0xFF×0x02 with `in_signed=0` → `0x01FE`.
- Streaming: 20 back-to-back random pairs with mixed `in_signed` and `out_ready=1` → `in_ready` stays 1, 20 consecutive correct results in order, checked against a reference model.
- Backpressure: full pipeline, drop `out_ready` for 5 cycles → `in_ready=0` the same cycles, `out_product` stable, no result lost or duplicated after resume. Also random `out_valid`/`out_ready` toggling for 1000 operations.
- Reset mid-flight: 4 operations in flight, `rst_n=0` for one edge → `out_valid=0` and `out_product=0` next cycle, and none of the 4 results ever emerge. A new operation afterwards completes in 8 cycles.
- `WIDTH=16`, `BPS=4`: latency 4 cycles. 0xFFFF×0xFFFF unsigned → `0xFFFE0001`; signed → `0x00000001`. Separately, `BPS=3` with `WIDTH=16` fails elaboration.
